jts16_ana_accum: RTL

- Upstream feeder of the System 16B cabinet I/O block: turns analogue-stick deflection and digital direction bits into free-running trackball-style position counters.
- Cabinet I/O reads these counters for trackball, spinner and dial games (SDI, Exciting League, Dunk Shot).
- Updates at a line-rate cadence derived from LHBL; channels are serviced one per clock by a small scan FSM.
- Provides a coherent snapshot register for CPU reads.

---
 rtl/jts16_ana_accum_pkg.sv | 19 +
 rtl/jts16_ana_step.sv | 39 +++
 rtl/jts16_ana_accum.sv | 139 +++++++++++++
 3 files changed

// File: rtl/jts16_ana_accum_pkg.sv
// Shared types and defaults for the analogue/digital position accumulator.
// Holds the scan FSM encoding and the default step-shaping constants.
package jts16_ana_accum_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    localparam int DEF_DEAD     = 8;
    localparam int DEF_SHIFT    = 4;
    localparam int DEF_DIG_STEP = 2;

    // Magnitude of a signed byte; -128 maps to 128, which fits unsigned 8 bits
    function automatic logic [7:0] abs8(input logic [7:0] v);
        return v[7] ? 8'(~v + 8'd1) : v;
    endfunction

endpackage

// File: rtl/jts16_ana_step.sv
// Per-channel step: digital direction wins, otherwise deadzoned and scaled
// analogue deflection. Purely combinational.
module jts16_ana_step
    import jts16_ana_accum_pkg::*;
#(
    parameter int W        = 12,
    parameter int DEAD     = DEF_DEAD,
    parameter int SHIFT    = DEF_SHIFT,
    parameter int DIG_STEP = DEF_DIG_STEP
) (
    input  logic [7:0]   ana,
    input  logic         up,
    input  logic         dn,
    output logic [W-1:0] step
);

    logic [7:0]   mag;
    logic [8:0]   over;
    logic [8:0]   rate;
    logic [W-1:0] rate_w;
    logic         in_dead;

    always_comb begin
        mag     = abs8(ana);
        in_dead = ({1'b0, mag} <= 9'(DEAD));
        over    = {1'b0, mag} - 9'(DEAD);
        rate    = over >> SHIFT;
        // Any deflection past the deadzone moves at least one count
        if (rate == 9'd0) rate = 9'd1;
        rate_w  = W'(rate);

        if (up && !dn)      step = W'(DIG_STEP);
        else if (dn && !up) step = W'(-DIG_STEP);
        else if (in_dead)   step = '0;
        else if (ana[7])    step = -rate_w;
        else                step = rate_w;
    end

endmodule

// File: rtl/jts16_ana_accum.sv
// Line-rate position counters fed by analogue sticks and digital directions,
// scanned one channel per clock, with a coherent snapshot for CPU reads.
module jts16_ana_accum
    import jts16_ana_accum_pkg::*;
#(
    parameter int CH       = 8,
    parameter int W        = 12,
    parameter int DEAD     = DEF_DEAD,
    parameter int SHIFT    = DEF_SHIFT,
    parameter int DIG_STEP = DEF_DIG_STEP,
    parameter int LINES    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            LHBL,
    input  logic [CH*8-1:0] ana,
    input  logic [CH-1:0]   dig_up,
    input  logic [CH-1:0]   dig_dn,
    input  logic            clear,
    input  logic            latch,
    output logic [CH*W-1:0] cnt,
    output logic [CH*W-1:0] snap,
    output logic            busy
);

    localparam int LW = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int IW = (CH > 1) ? $clog2(CH) : 1;

    logic          lhbl_l;
    logic [LW-1:0] line_cnt;
    logic          fall;
    logic          tick;

    state_t        st;
    logic [IW-1:0] idx;
    logic          pending;

    logic [W-1:0]  cnt_q  [CH];
    logic [W-1:0]  snap_q [CH];

    logic [7:0]    ana_sel;
    logic          up_sel;
    logic          dn_sel;
    logic [W-1:0]  step;

    // Line-rate tick from LHBL falling edges
    assign fall = lhbl_l & ~LHBL;
    assign tick = fall && (line_cnt == LW'(LINES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lhbl_l   <= 1'b1;
            line_cnt <= '0;
        end else begin
            lhbl_l <= LHBL;
            if (fall) line_cnt <= tick ? '0 : line_cnt + LW'(1);
        end
    end

    // Scan FSM; a tick landing mid-scan is queued once in pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= ST_IDLE;
            idx     <= '0;
            pending <= 1'b0;
            busy    <= 1'b0;
        end else begin
            busy <= (st == ST_SCAN);
            case (st)
                ST_IDLE: begin
                    if (tick || pending) begin
                        st      <= ST_SCAN;
                        idx     <= '0;
                        pending <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (tick) pending <= 1'b1;
                    idx <= idx + IW'(1);
                    if (idx == IW'(CH - 1)) st <= ST_IDLE;
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ana_sel = '0;
        up_sel  = 1'b0;
        dn_sel  = 1'b0;
        for (int k = 0; k < CH; k++) begin
            if (idx == IW'(k)) begin
                ana_sel = ana[k*8 +: 8];
                up_sel  = dig_up[k];
                dn_sel  = dig_dn[k];
            end
        end
    end

    jts16_ana_step #(
        .W        (W),
        .DEAD     (DEAD),
        .SHIFT    (SHIFT),
        .DIG_STEP (DIG_STEP)
    ) u_step (
        .ana  (ana_sel),
        .up   (up_sel),
        .dn   (dn_sel),
        .step (step)
    );

    // clear wins over a same-cycle channel update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < CH; k++) cnt_q[k] <= '0;
        end else if (clear) begin
            for (int k = 0; k < CH; k++) cnt_q[k] <= '0;
        end else if (st == ST_SCAN) begin
            for (int k = 0; k < CH; k++) begin
                if (idx == IW'(k)) cnt_q[k] <= cnt_q[k] + step;
            end
        end
    end

    // Snapshot takes the pre-edge counter values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < CH; k++) snap_q[k] <= '0;
        end else if (latch) begin
            for (int k = 0; k < CH; k++) snap_q[k] <= cnt_q[k];
        end
    end

    for (genvar k = 0; k < CH; k++) begin : g_out
        assign cnt[k*W +: W]  = cnt_q[k];
        assign snap[k*W +: W] = snap_q[k];
    end

endmodule
